i2c_word_tx: RTL and testbench

- Open-drain I2C write-only master that serializes the 24-bit CODEC configuration words (slave address, sub-address, register data) produced by the audio codec controller onto the SCLK/SDAT pins.
- Consumes the controller's `TRANSACTION_REQ`/`DATA` stream and returns a one-cycle `NEXT_WORD` pulse per acknowledged word.
- Sits between the configuration ROM sequencer and the board I2C pins inside `audio_codec_controller`.

---
 rtl/i2c_tx_pkg.sv | 29 ++
 rtl/i2c_word_tx_quarter_tick.sv | 44 ++++
 rtl/i2c_word_tx.sv | 149 ++++++++++++++
 tb/tb_i2c_word_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_tx_pkg.sv
// Shared types and slot constants for the I2C word transmitter.
package i2c_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BIT,
      ST_STOP,
      ST_DONE
   } i2c_state_t;

   typedef enum logic [1:0] {
      Q0,
      Q1,
      Q2,
      Q3
   } i2c_q_t;

   localparam int         SLOTS_PER_WORD = 27;
   localparam logic [4:0] LAST_SLOT      = 5'(SLOTS_PER_WORD - 1);
   localparam logic [4:0] ACK_SLOT_0     = 5'd8;
   localparam logic [4:0] ACK_SLOT_1     = 5'd17;
   localparam logic [4:0] ACK_SLOT_2     = 5'd26;

   function automatic logic is_ack_slot(input logic [4:0] slot);
      return (slot == ACK_SLOT_0) || (slot == ACK_SLOT_1) || (slot == ACK_SLOT_2);
   endfunction

endpackage

// File: rtl/i2c_word_tx_quarter_tick.sv
// SCL quarter-period timer: down-counter with terminal-count tick and 2-bit quarter index.
module i2c_quarter_tick #(
   parameter int QUARTER = 500
) (
   input  logic       CLOCK_50,
   input  logic       rst_n,
   input  logic       clr,
   output logic       tick,
   output logic [1:0] q_idx
);

   localparam int            CW     = (QUARTER > 1) ? $clog2(QUARTER) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(QUARTER - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    q_q, q_d;

   // Tick is suppressed while cleared so the FSM never sees a stale quarter advance.
   always_comb begin
      tick  = ~clr & (cnt_q == '0);
      cnt_d = cnt_q - CW'(1);
      q_d   = q_q;
      if (clr) begin
         cnt_d = RELOAD;
         q_d   = 2'd0;
      end else if (tick) begin
         cnt_d = RELOAD;
         q_d   = q_q + 2'd1;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= RELOAD;
         q_q   <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
         q_q   <= q_d;
      end
   end

   assign q_idx = q_q;

endmodule

// File: rtl/i2c_word_tx.sv
// Open-drain write-only I2C master sending one 24-bit codec configuration word per request.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | bus released, waiting for TRANSACTION_REQ, latches DATA
//  ST_START | one SCL period carrying the start condition
//  ST_BIT   | 27 slots: 3 x (8 data bits + ACK), early exit on NACK
//  ST_STOP  | one SCL period carrying the stop condition
//  ST_DONE  | single cycle: NEXT_WORD pulse or NACK bookkeeping
module i2c_word_tx
   import i2c_tx_pkg::*;
#(
   parameter int QUARTER = 500
) (
   input  logic        CLOCK_50,
   input  logic        rst_n,
   input  logic [23:0] DATA,
   input  logic        TRANSACTION_REQ,
   input  logic        I2C_SDAT_IN,
   output logic        NEXT_WORD,
   output logic        I2C_SCLK,
   output logic        I2C_SDAT_OE,
   output logic        BUSY,
   output logic        ACK_ERR,
   output logic [7:0]  ERR_CNT
);

   i2c_state_t  state_q, state_d;
   logic [4:0]  slot_q, slot_d;
   logic [23:0] shift_q, shift_d;
   logic        nack_q, nack_d;
   logic        sclk_q, sclk_d;
   logic        sda_oe_q, sda_oe_d;
   logic        next_word_q, next_word_d;
   logic        ack_err_q, ack_err_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   logic        clr;
   logic        tick;
   logic [1:0]  q_idx;
   i2c_q_t      q_cur, q_nxt;
   logic        last_q;

   assign clr = (state_q == ST_IDLE) || (state_q == ST_DONE);

   i2c_quarter_tick #(.QUARTER(QUARTER)) u_quarter_tick (
      .CLOCK_50 (CLOCK_50),
      .rst_n    (rst_n),
      .clr      (clr),
      .tick     (tick),
      .q_idx    (q_idx)
   );

   always_comb begin
      q_cur       = i2c_q_t'(q_idx);
      q_nxt       = tick ? i2c_q_t'(q_idx + 2'd1) : q_cur;
      last_q      = tick && (q_cur == Q3);
      state_d     = state_q;
      slot_d      = slot_q;
      shift_d     = shift_q;
      nack_d      = nack_q;
      ack_err_d   = ack_err_q;
      err_cnt_d   = err_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (TRANSACTION_REQ) begin
               shift_d = DATA;
               slot_d  = 5'd0;
               nack_d  = 1'b0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (last_q) state_d = ST_BIT;
         end
         ST_BIT: begin
            // ACK is sampled on the final cycle of the SCL high phase.
            if (is_ack_slot(slot_q) && tick && (q_cur == Q2)) nack_d = I2C_SDAT_IN;
            if (last_q) begin
               if (!is_ack_slot(slot_q)) shift_d = {shift_q[22:0], 1'b0};
               if ((is_ack_slot(slot_q) && nack_q) || (slot_q == LAST_SLOT)) state_d = ST_STOP;
               else slot_d = slot_q + 5'd1;
            end
         end
         ST_STOP: begin
            if (last_q) begin
               state_d   = ST_DONE;
               ack_err_d = nack_q;
               if (nack_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Pin levels are decoded from the upcoming state so they line up with the quarter grid.
      sclk_d   = 1'b1;
      sda_oe_d = 1'b0;
      case (state_d)
         ST_START: begin
            sclk_d   = (q_nxt != Q3);
            sda_oe_d = (q_nxt != Q0);
         end
         ST_BIT: begin
            sclk_d   = (q_nxt == Q1) || (q_nxt == Q2);
            sda_oe_d = !is_ack_slot(slot_d) && !shift_d[23];
         end
         ST_STOP: begin
            sclk_d   = (q_nxt != Q0);
            sda_oe_d = (q_nxt == Q0) || (q_nxt == Q1);
         end
         default: ;
      endcase
      next_word_d = (state_d == ST_DONE) && !nack_q;
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         slot_q      <= 5'd0;
         shift_q     <= 24'd0;
         nack_q      <= 1'b0;
         sclk_q      <= 1'b1;
         sda_oe_q    <= 1'b0;
         next_word_q <= 1'b0;
         ack_err_q   <= 1'b0;
         err_cnt_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         shift_q     <= shift_d;
         nack_q      <= nack_d;
         sclk_q      <= sclk_d;
         sda_oe_q    <= sda_oe_d;
         next_word_q <= next_word_d;
         ack_err_q   <= ack_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign I2C_SCLK    = sclk_q;
   assign I2C_SDAT_OE = sda_oe_q;
   assign NEXT_WORD   = next_word_q;
   assign ACK_ERR     = ack_err_q;
   assign ERR_CNT     = err_cnt_q;
   assign BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_word_tx.sv
// Directed bench for i2c_word_tx: I2C responder/decoder, protocol watcher and word scoreboard.
module tb_i2c_word_tx;

   localparam int QUARTER = 4;

   logic        CLOCK_50 = 1'b0;
   logic        rst_n;
   logic [23:0] DATA;
   logic        TRANSACTION_REQ;
   logic        NEXT_WORD;
   logic        I2C_SCLK;
   logic        I2C_SDAT_OE;
   logic        BUSY;
   logic        ACK_ERR;
   logic [7:0]  ERR_CNT;
   logic        sda_line;

   logic        resp_low = 1'b0;
   logic        mon_en = 1'b0;
   int          nack_byte = -1;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          nw_cnt = 0;
   int          proto_err = 0;
   int          last_nbytes = 0;

   logic [23:0] exp_q[$];
   logic [23:0] got_q[$];

   assign sda_line = ~(I2C_SDAT_OE | resp_low);

   i2c_word_tx #(.QUARTER(QUARTER)) dut (
      .CLOCK_50        (CLOCK_50),
      .rst_n           (rst_n),
      .DATA            (DATA),
      .TRANSACTION_REQ (TRANSACTION_REQ),
      .I2C_SDAT_IN     (sda_line),
      .NEXT_WORD       (NEXT_WORD),
      .I2C_SCLK        (I2C_SCLK),
      .I2C_SDAT_OE     (I2C_SDAT_OE),
      .BUSY            (BUSY),
      .ACK_ERR         (ACK_ERR),
      .ERR_CNT         (ERR_CNT)
   );

   initial forever #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   always @(negedge CLOCK_50) if (NEXT_WORD) nw_cnt <= nw_cnt + 1;

   // Responder: decodes bytes on SCL rise, drives ACK low after each byte unless told to NACK it.
   logic       prev_scl = 1'b1;
   logic       prev_sda = 1'b1;
   logic       in_xfer = 1'b0;
   int         bitcnt = 0;
   int         nbytes = 0;
   logic [7:0] byte_sr = 8'd0;
   logic [23:0] word_sr = 24'd0;

   always @(negedge CLOCK_50) begin
      prev_scl <= I2C_SCLK;
      prev_sda <= sda_line;
      if (!mon_en) begin
         in_xfer  <= 1'b0;
         bitcnt   <= 0;
         nbytes   <= 0;
         resp_low <= 1'b0;
      end else if (prev_scl && I2C_SCLK && prev_sda && !sda_line) begin
         if (in_xfer) proto_err <= proto_err + 1;
         in_xfer <= 1'b1;
         bitcnt  <= 0;
         nbytes  <= 0;
         word_sr <= 24'd0;
      end else if (prev_scl && I2C_SCLK && !prev_sda && sda_line) begin
         // A legal stop follows a byte boundary plus the stop's own SCL rise.
         if (!in_xfer || bitcnt != 1) proto_err <= proto_err + 1;
         in_xfer     <= 1'b0;
         last_nbytes <= nbytes;
         if (nbytes == 3) got_q.push_back(word_sr);
      end else if (in_xfer && !prev_scl && I2C_SCLK) begin
         if (bitcnt < 8) byte_sr <= {byte_sr[6:0], sda_line};
         bitcnt <= bitcnt + 1;
      end else if (in_xfer && prev_scl && !I2C_SCLK) begin
         if (bitcnt == 8) begin
            resp_low <= (nack_byte != nbytes);
            word_sr  <= {word_sr[15:0], byte_sr};
         end else if (bitcnt == 9) begin
            resp_low <= 1'b0;
            bitcnt   <= 0;
            nbytes   <= nbytes + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic wait_busy(input logic lvl, input int budget, input string tag, output int at);
      bit ok = 1'b0;
      at = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge CLOCK_50);
         if (BUSY === lvl) begin
            ok = 1'b1;
            at = cyc;
         end
      end
      check(tag, 32'(ok), 1);
   endtask

   task automatic wait_nw(input int budget, input string tag, output int at);
      bit ok = 1'b0;
      at = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge CLOCK_50);
         if (NEXT_WORD === 1'b1) begin
            ok = 1'b1;
            at = cyc;
         end
      end
      check(tag, 32'(ok), 1);
   endtask

   task automatic compare_word(input string tag);
      logic [23:0] g, e;
      bit have;
      have = (got_q.size() > 0) && (exp_q.size() > 0);
      check({tag, "_avail"}, 32'(have), 1);
      if (have) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         check(tag, 32'(g), 32'(e));
      end
   endtask

   initial begin
      int t0, t1, nw_base;
      logic [23:0] w;

      rst_n = 1'b0;
      TRANSACTION_REQ = 1'b0;
      DATA = 24'd0;
      repeat (3) @(negedge CLOCK_50);
      check("rst_sclk", 32'(I2C_SCLK), 1);
      check("rst_sda_oe", 32'(I2C_SDAT_OE), 0);
      check("rst_next_word", 32'(NEXT_WORD), 0);
      check("rst_busy", 32'(BUSY), 0);
      check("rst_ack_err", 32'(ACK_ERR), 0);
      check("rst_err_cnt", 32'(ERR_CNT), 0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      repeat (3) @(negedge CLOCK_50);

      // Basic word
      DATA = 24'h34_1201;
      TRANSACTION_REQ = 1'b1;
      exp_q.push_back(DATA);
      wait_busy(1'b1, 20, "basic_start", t0);
      wait_nw(600, "basic_nw", t1);
      TRANSACTION_REQ = 1'b0;
      check("basic_latency", 32'(t1 - t0), 464);
      check("basic_ack_err", 32'(ACK_ERR), 0);
      compare_word("basic_word");
      repeat (5) @(negedge CLOCK_50);
      check("basic_nw_once", 32'(nw_cnt), 1);

      // Address NACK then ACKed retry
      nack_byte = 0;
      DATA = 24'hA0_5566;
      TRANSACTION_REQ = 1'b1;
      wait_busy(1'b1, 20, "nack_start", t0);
      wait_busy(1'b0, 400, "nack_done", t1);
      check("nack_latency", 32'(t1 - t0 - 1), 176);
      check("nack_ack_err", 32'(ACK_ERR), 1);
      check("nack_err_cnt", 32'(ERR_CNT), 1);
      check("nack_stop_after_addr", 32'(last_nbytes), 1);
      check("nack_no_next_word", 32'(nw_cnt), 1);
      nack_byte = -1;
      exp_q.push_back(24'hA0_5566);
      wait_busy(1'b1, 5, "retry_start", t0);
      wait_nw(600, "retry_nw", t1);
      TRANSACTION_REQ = 1'b0;
      check("retry_ack_err", 32'(ACK_ERR), 0);
      compare_word("retry_word");

      // Controller model: ten words advanced on NEXT_WORD
      repeat (4) @(negedge CLOCK_50);
      nw_base = nw_cnt;
      for (int i = 0; i < 10; i++) begin
         w = {8'h34, 8'(i), 8'(8'hC0 + i)};
         DATA = w;
         TRANSACTION_REQ = 1'b1;
         exp_q.push_back(w);
         wait_nw(600, "seq_nw", t1);
         compare_word("seq_word");
      end
      TRANSACTION_REQ = 1'b0;
      repeat (8) @(negedge CLOCK_50);
      check("seq_busy_low", 32'(BUSY), 0);
      check("seq_nw_count", 32'(nw_cnt - nw_base), 10);
      check("seq_no_extra_word", 32'(got_q.size()), 0);

      // DATA and REQ change during bit 5
      DATA = 24'hC3_A55A;
      TRANSACTION_REQ = 1'b1;
      exp_q.push_back(DATA);
      wait_busy(1'b1, 20, "mid_start", t0);
      repeat (98) @(negedge CLOCK_50);
      DATA = 24'hFF_FFFF;
      TRANSACTION_REQ = 1'b0;
      wait_nw(600, "mid_nw", t1);
      compare_word("mid_word");
      repeat (4) @(negedge CLOCK_50);

      // Reset during slot 2 Q0 (SCL low, SDA driven low)
      DATA = 24'h12_3456;
      TRANSACTION_REQ = 1'b1;
      wait_busy(1'b1, 20, "rstmid_start", t0);
      repeat (49) @(negedge CLOCK_50);
      check("pre_rst_sclk", 32'(I2C_SCLK), 0);
      check("pre_rst_sda_oe", 32'(I2C_SDAT_OE), 1);
      #1;
      rst_n = 1'b0;
      mon_en = 1'b0;
      #1;
      check("rstmid_sclk", 32'(I2C_SCLK), 1);
      check("rstmid_sda_oe", 32'(I2C_SDAT_OE), 0);
      check("rstmid_busy", 32'(BUSY), 0);
      check("rstmid_next_word", 32'(NEXT_WORD), 0);
      check("rstmid_ack_err", 32'(ACK_ERR), 0);
      check("rstmid_err_cnt", 32'(ERR_CNT), 0);
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      rst_n = 1'b1;
      mon_en = 1'b1;
      exp_q.push_back(24'h12_3456);
      wait_busy(1'b1, 20, "rstmid_restart", t0);
      wait_nw(600, "rstmid_nw", t1);
      TRANSACTION_REQ = 1'b0;
      compare_word("rstmid_word");
      repeat (4) @(negedge CLOCK_50);

      // 256 consecutive NACKs
      nack_byte = 0;
      DATA = 24'h40_0000;
      TRANSACTION_REQ = 1'b1;
      for (int i = 0; i < 256; i++) begin
         wait_busy(1'b1, 20, "sat_start", t0);
         wait_busy(1'b0, 400, "sat_done", t1);
         if (i == 0) check("sat_first", 32'(ERR_CNT), 1);
         if (i == 254) check("sat_reach_255", 32'(ERR_CNT), 255);
      end
      TRANSACTION_REQ = 1'b0;
      nack_byte = -1;
      check("sat_hold_255", 32'(ERR_CNT), 255);
      check("sat_ack_err", 32'(ACK_ERR), 1);

      repeat (6) @(negedge CLOCK_50);
      check("final_busy", 32'(BUSY), 0);
      check("protocol_violations", 32'(proto_err), 0);
      check("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
